fp_div: RTL and testbench

- Sequential IEEE-754 binary32 divider; computes op = a / b. It is the inverse-operation companion to the team's combinational FP multiplier.
- Mantissa quotient is produced by an iterative restoring shift-subtract loop with start/busy/finish handshake.
- Sits beside the multiplier in the FP unit and is driven by the MIPS datapath when a divide is issued.
- NaN encodings match the multiplier: quiet NaN 0x7FC00000 for a NaN input; 0xFFC00000 for invalid operations.

---
 rtl/fp_div.sv | 267 ++++++++++++++++++++++++++
 tb/tb_fp_div.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div.sv
// fp_div: sequential IEEE-754 binary32 divider, op = a / b.
//
// The mantissa quotient comes from a restoring shift-subtract loop that
// retires BITS_PER_CYC quotient bits per clock (1 or 2). Denormal inputs are
// flushed to zero, the result is rounded to nearest-even, and results that
// leave the normal range saturate to signed Inf or flush to signed zero.
//
// Handshake: start is sampled only while busy=0. The accepting edge raises
// busy. finish is a one-cycle pulse with op valid in that same cycle. busy
// stays high during the finish cycle, so the next start is accepted one
// cycle after finish at the earliest. op holds until the next finish.
//
// Optional build macro FPDIV_FLAGS_EN adds
//   flags[4:0] = {invalid, divzero, overflow, underflow, inexact},
// registered alongside op.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high
//   start   request, sampled when busy=0
//   a, b    dividend / divisor, binary32
//   op      result, binary32
//   busy    operation in flight
//   finish  one-cycle completion pulse
//   flags   exception flags (FPDIV_FLAGS_EN builds only)
module fp_div #(
  parameter int BITS_PER_CYC = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] op,
  output logic        busy,
  output logic        finish
`ifdef FPDIV_FLAGS_EN
  ,
  output logic [4:0]  flags
`endif
);

  generate
    if (BITS_PER_CYC != 1 && BITS_PER_CYC != 2) begin : g_bad_param
      $error("fp_div: BITS_PER_CYC must be 1 or 2");
    end
  endgenerate

  localparam logic [4:0] LAST_CNT = 5'(26 / BITS_PER_CYC - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DIV     = 3'd1;
  localparam logic [2:0] S_ROUND   = 3'd2;
  localparam logic [2:0] S_SPECIAL = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // Operand class: {nan, inf, zero}. Exponent 0 counts as zero, so
  // denormals are flushed here.
  function automatic logic [2:0] op_class(input logic [31:0] x);
    logic exp_ones;
    logic frac_nz;
    exp_ones = &x[30:23];
    frac_nz  = |x[22:0];
    return {exp_ones & frac_nz, exp_ones & ~frac_nz, ~|x[30:23]};
  endfunction

  logic [2:0]        state;
  logic [31:0]       a_r;
  logic [31:0]       b_r;
  logic [24:0]       rem;
  logic [25:0]       quo;
  logic [4:0]        cnt;
  logic signed [9:0] exp_r;
  logic [31:0]       result;

  logic              go_special;
  logic [2:0]        in_cls_a;
  logic [2:0]        in_cls_b;

  logic              sign;
  logic [2:0]        cls_a;
  logic [2:0]        cls_b;
  logic [31:0]       sp_value;

  logic [24:0]       rem_n;
  logic [25:0]       quo_n;
  logic [23:0]       div_d;

  logic              sticky;
  logic              guard;
  logic [22:0]       frac;
  logic              round_up;
  logic [23:0]       frac_sum;
  logic signed [9:0] e_n;
  logic              ovf;
  logic              unf;
  logic [31:0]       rnd_value;

`ifdef FPDIV_FLAGS_EN
  logic [4:0]        sp_flags;
  logic [4:0]        rnd_flags;
  logic [4:0]        flags_r;
`endif

  // Any zero, Inf or NaN operand takes the special path.
  assign in_cls_a   = op_class(a);
  assign in_cls_b   = op_class(b);
  assign go_special = (|in_cls_a) | (|in_cls_b);

  assign sign  = a_r[31] ^ b_r[31];
  assign cls_a = op_class(a_r);
  assign cls_b = op_class(b_r);

  // Special-case result, highest priority first.
  always_comb begin
    sp_value = {sign, 31'd0};
`ifdef FPDIV_FLAGS_EN
    sp_flags = 5'd0;
`endif
    if (cls_a[2] | cls_b[2]) begin
      sp_value = 32'h7FC0_0000;
`ifdef FPDIV_FLAGS_EN
      sp_flags = 5'b10000;
`endif
    end else if ((cls_a[1] & cls_b[1]) | (cls_a[0] & cls_b[0])) begin
      sp_value = 32'hFFC0_0000;
`ifdef FPDIV_FLAGS_EN
      sp_flags = 5'b10000;
`endif
    end else if (cls_a[1]) begin
      sp_value = {sign, 8'hFF, 23'd0};
    end else if (cls_b[0]) begin
      sp_value = {sign, 8'hFF, 23'd0};
`ifdef FPDIV_FLAGS_EN
      sp_flags = 5'b01000;
`endif
    end else begin
      sp_value = {sign, 31'd0};
    end
  end

  // Restoring divide step(s). The remainder stays below D after each
  // compare, so the left shift never loses its top bit.
  assign div_d = {1'b1, b_r[22:0]};

  always_comb begin
    rem_n = rem;
    quo_n = quo;
    for (int i = 0; i < BITS_PER_CYC; i++) begin
      if (rem_n >= {1'b0, div_d}) begin
        rem_n = rem_n - {1'b0, div_d};
        quo_n = {quo_n[24:0], 1'b1};
      end else begin
        quo_n = {quo_n[24:0], 1'b0};
      end
      rem_n = {rem_n[23:0], 1'b0};
    end
  end

  // Normalise, round to nearest-even, then range-check.
  always_comb begin
    sticky = |rem;
    e_n    = exp_r;
    if (quo[25]) begin
      frac   = quo[24:2];
      guard  = quo[1];
      sticky = sticky | quo[0];
    end else begin
      frac  = quo[23:1];
      guard = quo[0];
      e_n   = exp_r - 10'sd1;
    end
    round_up = guard & (sticky | frac[0]);
    frac_sum = {1'b0, frac} + {23'd0, round_up};
    // A carry out leaves frac_sum[22:0] all zero, which is the new mantissa.
    if (frac_sum[23]) begin
      e_n = e_n + 10'sd1;
    end
    ovf = (e_n >= 10'sd255);
    unf = (e_n <= 10'sd0);
    if (ovf) begin
      rnd_value = {sign, 8'hFF, 23'd0};
    end else if (unf) begin
      rnd_value = {sign, 31'd0};
    end else begin
      rnd_value = {sign, e_n[7:0], frac_sum[22:0]};
    end
  end

`ifdef FPDIV_FLAGS_EN
  assign rnd_flags = {1'b0, 1'b0, ovf, unf, guard | sticky | ovf | unf};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
      exp_r  <= '0;
      result <= '0;
      op     <= '0;
      busy   <= 1'b0;
      finish <= 1'b0;
`ifdef FPDIV_FLAGS_EN
      flags_r <= '0;
      flags   <= '0;
`endif
    end else begin
      finish <= 1'b0;
      case (state)
        S_IDLE: begin
          // busy is still high in the finish cycle; clear it here so that
          // a start coinciding with finish is ignored.
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            a_r   <= a;
            b_r   <= b;
            busy  <= 1'b1;
            rem   <= {2'b01, a[22:0]};
            quo   <= '0;
            cnt   <= '0;
            exp_r <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
            state <= go_special ? S_SPECIAL : S_DIV;
          end
        end
        S_DIV: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + 5'd1;
          if (cnt == LAST_CNT) begin
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          result <= rnd_value;
`ifdef FPDIV_FLAGS_EN
          flags_r <= rnd_flags;
`endif
          state <= S_DONE;
        end
        S_SPECIAL: begin
          result <= sp_value;
`ifdef FPDIV_FLAGS_EN
          flags_r <= sp_flags;
`endif
          state <= S_DONE;
        end
        S_DONE: begin
          op     <= result;
          finish <= 1'b1;
`ifdef FPDIV_FLAGS_EN
          flags <= flags_r;
`endif
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// tb_fp_div: directed-vector bench for fp_div. Two instances are driven from
// the same operand bus: u_dut1 (BITS_PER_CYC=1, 28-cycle normal latency) and
// u_dut2 (BITS_PER_CYC=2, 15-cycle normal latency). Special cases finish two
// cycles after the accepting edge in both.
module tb_fp_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1;
  logic        start2;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy1;
  logic        busy2;
  logic        finish1;
  logic        finish2;
`ifdef FPDIV_FLAGS_EN
  logic [4:0]  flags1;
  logic [4:0]  flags2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_div #(.BITS_PER_CYC(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a), .b(b),
    .op(op1), .busy(busy1), .finish(finish1)
`ifdef FPDIV_FLAGS_EN
    , .flags(flags1)
`endif
  );

  fp_div #(.BITS_PER_CYC(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .a(a), .b(b),
    .op(op2), .busy(busy2), .finish(finish2)
`ifdef FPDIV_FLAGS_EN
    , .flags(flags2)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_op;
    bit          special;
    logic [4:0]  exp_fl;
  } vec_t;

  vec_t vecs[14];

  function automatic logic fin(input int sel);
    return (sel == 2) ? finish2 : finish1;
  endfunction

  function automatic logic bsy(input int sel);
    return (sel == 2) ? busy2 : busy1;
  endfunction

  function automatic logic [31:0] opv(input int sel);
    return (sel == 2) ? op2 : op1;
  endfunction

`ifdef FPDIV_FLAGS_EN
  function automatic logic [4:0] flv(input int sel);
    return (sel == 2) ? flags2 : flags1;
  endfunction
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive a start pulse; returns #1 after the accepting edge.
  task automatic do_start(input int sel, input logic [31:0] x, input logic [31:0] y);
    a = x;
    b = y;
    if (sel == 2) start2 = 1'b1;
    else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Wait for finish, counting cycles from the current point. With post=1 it
  // also steps one more cycle to check that finish was a single pulse.
  task automatic wait_done(input int sel, input int exp_lat, input logic [31:0] exp_op,
                           input logic [4:0] exp_fl, input bit post, input string name);
    int  cyc;
    bit  seen;
    bit  busy_ok;
    cyc     = 0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(posedge clk);
      #1;
      cyc = i;
      if (fin(sel)) seen = 1'b1;
      else if (!bsy(sel)) busy_ok = 1'b0;
    end
    check({name, " finish_seen"}, 32'(seen), 32'd1);
    check({name, " latency"}, 32'(cyc), 32'(exp_lat));
    check({name, " busy_held"}, 32'(busy_ok & bsy(sel)), 32'd1);
    check({name, " op"}, opv(sel), exp_op);
`ifdef FPDIV_FLAGS_EN
    check({name, " flags"}, 32'(flv(sel)), 32'(exp_fl));
`else
    if (exp_fl != exp_fl) $display("unreachable");
`endif
    if (post) begin
      @(posedge clk);
      #1;
      check({name, " one_pulse"}, 32'(fin(sel)), 32'd0);
      check({name, " op_hold"}, opv(sel), exp_op);
    end
  endtask

  initial begin
    int pulses;
    int lat;

    vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 5'b00000};
    vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 5'b00001};
    vecs[2]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 5'b00000};
    vecs[3]  = '{32'h4000_0000, 32'hBF00_0000, 32'hC080_0000, 1'b0, 5'b00000};
    vecs[4]  = '{32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b0, 5'b00101};
    vecs[5]  = '{32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 5'b00011};
    vecs[6]  = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 5'b01000};
    vecs[7]  = '{32'h8000_0000, 32'h0000_0000, 32'hFFC0_0000, 1'b1, 5'b10000};
    vecs[8]  = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, 5'b10000};
    vecs[9]  = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b1, 5'b00000};
    vecs[10] = '{32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 1'b1, 5'b00000};
    vecs[11] = '{32'h7F80_0000, 32'hFF80_0000, 32'hFFC0_0000, 1'b1, 5'b10000};
    vecs[12] = '{32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 1'b1, 5'b00000};
    vecs[13] = '{32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000, 1'b1, 5'b00000};

    // Clock/reset
    reset  = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    a      = '0;
    b      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset op1", op1, 32'd0);
    check("reset busy1", 32'(busy1), 32'd0);
    check("reset finish1", 32'(finish1), 32'd0);
    check("reset op2", op2, 32'd0);
    check("reset busy2", 32'(busy2), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven vectors on both instances
    for (int i = 0; i < 14; i++) begin
      for (int sel = 1; sel <= 2; sel++) begin
        lat = vecs[i].special ? 2 : ((sel == 1) ? 28 : 15);
        do_start(sel, vecs[i].a, vecs[i].b);
        wait_done(sel, lat, vecs[i].exp_op, vecs[i].exp_fl, 1'b1,
                  $sformatf("vec%0d dut%0d", i, sel));
      end
    end

    // Start while busy with different operands: ignored, one finish only
    do_start(1, 32'h40C0_0000, 32'h4000_0000);
    a      = 32'h3F80_0000;
    b      = 32'h4040_0000;
    start1 = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    start1 = 1'b0;
    wait_done(1, 23, 32'h4040_0000, 5'b00000, 1'b1, "busy_start");
    pulses = 0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (finish1) pulses++;
    end
    check("busy_start extra_pulses", 32'(pulses), 32'd0);

    // Start held in the finish cycle: refused, accepted on the next edge
    do_start(1, 32'h3F80_0000, 32'h3F80_0000);
    wait_done(1, 28, 32'h3F80_0000, 5'b00000, 1'b0, "b2b first");
    a      = 32'h40C0_0000;
    b      = 32'h4000_0000;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    check("b2b refused_busy", 32'(busy1), 32'd0);
    check("b2b refused_finish", 32'(finish1), 32'd0);
    @(posedge clk);
    #1;
    start1 = 1'b0;
    check("b2b accepted_busy", 32'(busy1), 32'd1);
    wait_done(1, 28, 32'h4040_0000, 5'b00000, 1'b1, "b2b second");

    // Reset 10 cycles into a divide aborts it
    do_start(1, 32'h3F80_0000, 32'h4040_0000);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort op", op1, 32'd0);
    check("abort busy", 32'(busy1), 32'd0);
    check("abort finish", 32'(finish1), 32'd0);
    reset  = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (finish1 || busy1) pulses++;
    end
    check("abort no_activity", 32'(pulses), 32'd0);
    do_start(1, 32'h3F80_0000, 32'h4040_0000);
    wait_done(1, 28, 32'h3EAA_AAAB, 5'b00001, 1'b1, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
